// File: rtl/num_ascii_fmt.sv
// Purpose : binary-to-ASCII formatter (decimal via iterative double-dabble, or hex), MS digit first.
// Latency : accept on cycle 0 -> first char on cycle WIDTH+1 (decimal) or cycle 2 (hex); one char per cycle after that.
// Backpr. : out_char/out_last/out_ovf hold while out_ready is low; in_ready stays low until the last char is taken.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          value handshake; in_value, in_hex, in_lz sampled on accept
//   out_valid/out_ready        character handshake
//   out_char                   ASCII character
//   out_last                   asserted on the digit at position 0
//   out_ovf                    value did not fit in DIGITS positions (same on every char of the value)
module num_ascii_fmt #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5,
   parameter bit UPPER  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   input  logic             in_hex,
   input  logic             in_lz,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             out_last,
   output logic             out_ovf
);

   localparam int BW = DIGITS * 4;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = $clog2(DIGITS + 1);

   typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  val_q;
   logic [BW-1:0]     dig_q;
   logic [CW-1:0]     cnt_q;
   logic [IW-1:0]     idx_q;
   logic              hex_q, lz_q, ovf_q;
   logic              in_ready_q, out_valid_q, out_last_q, out_ovf_q;
   logic [7:0]        out_char_q;

   logic [BW-1:0]       adj;
   logic [WIDTH+BW-1:0] ext;
   logic [BW-1:0]       dig_d;
   logic                ovf_d;
   logic [IW-1:0]       lead_d;

   // Select nibble i of a digit vector (loop form avoids index-width overflow).
   function automatic logic [3:0] nib(input logic [BW-1:0] v, input logic [IW-1:0] i);
      logic [3:0] r;
      r = 4'd0;
      for (int d = 0; d < DIGITS; d++)
         if (i == IW'(d)) r = v[4*d +: 4];
      return r;
   endfunction

   function automatic logic [7:0] to_ascii(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      else           return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
   endfunction

   always_comb begin
      // Add-3 correction on every BCD digit >= 5 before the shift.
      adj = dig_q;
      for (int d = 0; d < DIGITS; d++)
         if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
      ext = {{BW{1'b0}}, val_q};
      if (hex_q) begin
         dig_d = ext[BW-1:0];
         ovf_d = |(ext >> BW);
      end else begin
         // Bit leaving the top BCD digit means the value is >= 10**DIGITS.
         dig_d = {adj[BW-2:0], val_q[WIDTH-1]};
         ovf_d = ovf_q | adj[BW-1];
      end
      // Highest nonzero digit when suppressing zeros; position 0 if all zero.
      lead_d = lz_q ? '0 : IW'(DIGITS - 1);
      if (lz_q)
         for (int d = 0; d < DIGITS; d++)
            if (dig_d[4*d +: 4] != 4'd0) lead_d = IW'(d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         val_q       <= '0;
         dig_q       <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         hex_q       <= 1'b0;
         lz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_char_q  <= 8'h00;
         out_last_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  val_q      <= in_value;
                  hex_q      <= in_hex;
                  lz_q       <= in_lz;
                  dig_q      <= '0;
                  ovf_q      <= 1'b0;
                  cnt_q      <= CW'(WIDTH - 1);
                  in_ready_q <= 1'b0;
                  state_q    <= CONV;
               end
            end
            CONV: begin
               val_q <= val_q << 1;
               dig_q <= dig_d;
               ovf_q <= ovf_d;
               cnt_q <= cnt_q - CW'(1);
               if (hex_q || cnt_q == '0) begin
                  state_q     <= EMIT;
                  idx_q       <= lead_d;
                  out_valid_q <= 1'b1;
                  out_char_q  <= to_ascii(nib(dig_d, lead_d));
                  out_last_q  <= (lead_d == '0);
                  out_ovf_q   <= ovf_d;
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     state_q     <= IDLE;
                     out_valid_q <= 1'b0;
                     out_char_q  <= 8'h00;
                     out_last_q  <= 1'b0;
                     out_ovf_q   <= 1'b0;
                     in_ready_q  <= 1'b1;
                  end else begin
                     idx_q      <= idx_q - IW'(1);
                     out_char_q <= to_ascii(nib(dig_q, idx_q - IW'(1)));
                     out_last_q <= (idx_q == IW'(1));
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_char  = out_char_q;
   assign out_last  = out_last_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_num_ascii_fmt.sv
// Purpose : scoreboard bench for num_ascii_fmt; two builds (16/5/upper and 16/4/lower) share the input side.
// Latency : not applicable.
// Backpr. : instance A's out_ready is forced or random; instance B's out_ready is always random.
module tb_num_ascii_fmt;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_value = '0;
   logic        in_hex = 1'b0;
   logic        in_lz = 1'b0;

   logic       in_ready_a, out_valid_a, out_ready_a, out_last_a, out_ovf_a;
   logic [7:0] out_char_a;
   logic       in_ready_b, out_valid_b, out_ready_b, out_last_b, out_ovf_b;
   logic [7:0] out_char_b;

   always #5 clk = ~clk;

   num_ascii_fmt #(.WIDTH(16), .DIGITS(5), .UPPER(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_value(in_value),
      .in_hex(in_hex), .in_lz(in_lz),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_char(out_char_a),
      .out_last(out_last_a), .out_ovf(out_ovf_a));

   num_ascii_fmt #(.WIDTH(16), .DIGITS(4), .UPPER(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_value(in_value),
      .in_hex(in_hex), .in_lz(in_lz),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_char(out_char_b),
      .out_last(out_last_b), .out_ovf(out_ovf_b));

   typedef struct {
      logic [7:0] c;
      logic       last;
      logic       ovf;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int hs_a    = 0;
   int acc_cyc = 0;
   int lat_exp = 0;
   bit lat_pend  = 1'b0;
   bit force_a   = 1'b1;
   bit force_val = 1'b1;

   bit         hold_a = 1'b0, mid_a = 1'b0, hold_b = 1'b0, mid_b = 1'b0;
   logic [7:0] pc_a, pc_b;
   logic       pl_a, po_a, pl_b, po_b;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // Reference: low D digits of v in base 10/16, MS first, zero suppression applied to the truncated digits.
   task automatic model(input bit which, input int unsigned v, input bit hex, input bit lz);
      int     d;
      bit     up;
      longint base, lim, t;
      int     dg[8];
      int     start;
      exp_t   e;
      d    = which ? 4 : 5;
      up   = which ? 1'b0 : 1'b1;
      base = hex ? 16 : 10;
      lim  = 1;
      for (int i = 0; i < d; i++) lim = lim * base;
      t = v % lim;
      for (int i = 0; i < d; i++) begin
         dg[i] = int'(t % base);
         t = t / base;
      end
      start = lz ? 0 : d - 1;
      if (lz)
         for (int i = 0; i < d; i++)
            if (dg[i] != 0) start = i;
      for (int i = start; i >= 0; i--) begin
         e.c    = (dg[i] < 10) ? 8'(48 + dg[i]) : 8'((up ? 65 : 97) + dg[i] - 10);
         e.last = (i == 0);
         e.ovf  = (longint'(v) >= lim);
         if (which) qb.push_back(e);
         else       qa.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int unsigned v, input bit hex, input bit lz, input int lat);
      int n;
      n = 0;
      while (!(in_ready_a && in_ready_b) && n < 2000) begin
         tick();
         n++;
      end
      if (n >= 2000) timeout("send_idle_wait");
      in_value = 16'(v);
      in_hex   = hex;
      in_lz    = lz;
      in_valid = 1'b1;
      model(1'b0, v, hex, lz);
      model(1'b1, v, hex, lz);
      if (lat > 0) begin
         lat_exp  = lat;
         acc_cyc  = cyc;
         lat_pend = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      // Scramble inputs so a value in flight cannot depend on them.
      in_value = 16'($urandom);
      in_hex   = 1'($urandom);
      in_lz    = 1'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!(in_ready_a && in_ready_b && qa.size() == 0 && qb.size() == 0) && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) timeout("drain_wait");
   endtask

   // Monitor: drives out_ready, then checks whatever will handshake on the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      out_ready_a = force_a ? force_val : ($urandom_range(0, 3) != 0);
      out_ready_b = ($urandom_range(0, 3) != 0);
      if (!rst_n) begin
         hold_a = 1'b0; mid_a = 1'b0;
         hold_b = 1'b0; mid_b = 1'b0;
      end else begin
         if (hold_a) begin
            chk("a_hold_valid", out_valid_a, 1);
            chk("a_hold_char", out_char_a, pc_a);
            chk("a_hold_last", out_last_a, pl_a);
            chk("a_hold_ovf", out_ovf_a, po_a);
         end
         if (mid_a) chk("a_no_bubble", out_valid_a, 1);
         if (out_valid_a) chk("a_in_ready_low", in_ready_a, 0);
         if (lat_pend && out_valid_a) begin
            chk("a_first_latency", cyc - acc_cyc, lat_exp);
            lat_pend = 1'b0;
         end
         if (out_valid_a && out_ready_a) begin
            if (qa.size() == 0) timeout("a_unexpected_char");
            else begin
               e = qa.pop_front();
               chk("a_char", out_char_a, e.c);
               chk("a_last", out_last_a, e.last);
               chk("a_ovf", out_ovf_a, e.ovf);
            end
            hs_a++;
            mid_a = !out_last_a;
         end
         hold_a = out_valid_a && !out_ready_a;
         pc_a = out_char_a; pl_a = out_last_a; po_a = out_ovf_a;

         if (hold_b) begin
            chk("b_hold_valid", out_valid_b, 1);
            chk("b_hold_char", out_char_b, pc_b);
            chk("b_hold_last", out_last_b, pl_b);
            chk("b_hold_ovf", out_ovf_b, po_b);
         end
         if (mid_b) chk("b_no_bubble", out_valid_b, 1);
         if (out_valid_b) chk("b_in_ready_low", in_ready_b, 0);
         if (out_valid_b && out_ready_b) begin
            if (qb.size() == 0) timeout("b_unexpected_char");
            else begin
               e = qb.pop_front();
               chk("b_char", out_char_b, e.c);
               chk("b_last", out_last_b, e.last);
               chk("b_ovf", out_ovf_b, e.ovf);
            end
            mid_b = !out_last_b;
         end
         hold_b = out_valid_b && !out_ready_b;
         pc_b = out_char_b; pl_b = out_last_b; po_b = out_ovf_b;
      end
   end

   initial begin
      int base, n;
      int unsigned v;
      int unsigned edge_vals[8] = '{0, 9, 10, 9999, 10000, 65535, 99999 % 65536, 16'hFFFF};

      // Reset state
      #1;
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_out_char", out_char_a, 0);
      chk("rst_out_last", out_last_a, 0);
      chk("rst_out_ovf", out_ovf_a, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready_a", in_ready_a, 1);
      chk("rst_in_ready_b", in_ready_b, 1);
      chk("rst_idle_valid", out_valid_a, 0);

      // Directed values, A never backpressured
      force_a = 1'b1; force_val = 1'b1;
      send(12345, 1'b0, 1'b0, 17); drain();
      send(42, 1'b0, 1'b0, 0);     drain();
      send(42, 1'b0, 1'b1, 0);     drain();
      send(0, 1'b0, 1'b1, 0);      drain();
      send(0, 1'b0, 1'b0, 0);      drain();
      send(16'hBEEF, 1'b1, 1'b1, 2); drain();
      send(16'hBEEF, 1'b1, 1'b0, 0); drain();
      send(65535, 1'b0, 1'b0, 0);  drain();
      send(9999, 1'b0, 1'b0, 0);   drain();
      send(0, 1'b1, 1'b1, 0);      drain();

      // Hold '3' of 12345 for three cycles
      send(12345, 1'b0, 1'b0, 17);
      n = 0;
      while (!(out_valid_a && out_char_a == 8'h33) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) timeout("bp_wait_char3");
      force_val = 1'b0;
      repeat (3) begin
         tick();
         chk("bp_valid", out_valid_a, 1);
         chk("bp_char", out_char_a, 8'h33);
         chk("bp_in_ready", in_ready_a, 0);
      end
      force_val = 1'b1;
      drain();

      // Reset in the middle of emission, after '1','2'
      base = hs_a;
      send(12345, 1'b0, 1'b0, 0);
      n = 0;
      while (hs_a - base < 2 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) timeout("rst_wait_two_chars");
      rst_n = 1'b0;
      #1;
      chk("midrst_valid_a", out_valid_a, 0);
      chk("midrst_valid_b", out_valid_b, 0);
      qa.delete();
      qb.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("postrst_in_ready_a", in_ready_a, 1);
      chk("postrst_in_ready_b", in_ready_b, 1);
      send(7, 1'b0, 1'b1, 17); drain();

      // Randomised values with random backpressure on both instances
      force_a = 1'b0;
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 20);
            1:       v = edge_vals[$urandom_range(0, 7)];
            default: v = 32'($urandom_range(0, 65535));
         endcase
         send(v, 1'($urandom), 1'($urandom), 0);
      end
      drain();
      chk("end_queue_a_empty", qa.size(), 0);
      chk("end_queue_b_empty", qb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
